// File: rtl/ltc5548_pio_irq_master_pkg.sv
// ltc5548_pio_pkg: PIO register map and service FSM states shared by the IRQ master.
package ltc5548_pio_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  typedef enum logic [2:0] {
    S_INIT_MASK,
    S_INIT_CLR,
    S_IDLE,
    S_MASK_WR,
    S_RD_CAP,
    S_RD_DAT,
    S_CLR,
    S_EMIT
  } state_t;
endpackage

// File: rtl/ltc5548_pio_irq_master_pio_bus_seq.sv
// pio_bus_seq: issues one registered Avalon-MM read or write to the PIO and flags its last cycle.
module pio_bus_seq #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        wr_i,
  input  logic [2:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [2:0]  avm_address_o,
  output logic        avm_chipselect_o,
  output logic        avm_write_n_o,
  output logic [31:0] avm_writedata_o,
  input  logic [31:0] avm_readdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o
);
  logic        cs_q, cs_d, wr_n_q, wr_n_d;
  logic [2:0]  addr_q, addr_d, cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  // A start issued on the done cycle chains the next access with no idle gap.
  assign done_o = cs_q && (!wr_n_q || cnt_q == 3'(READ_LATENCY));
  assign rdata_o = avm_readdata_i;
  assign avm_address_o = addr_q;
  assign avm_chipselect_o = cs_q;
  assign avm_write_n_o = wr_n_q;
  assign avm_writedata_o = wdata_q;
  always_comb begin
    cs_d = start_i || (cs_q && !done_o);
    wr_n_d = start_i ? !wr_i : (done_o || wr_n_q);
    addr_d = start_i ? addr_i : addr_q;
    wdata_d = start_i ? (wr_i ? wdata_i : '0) : (done_o ? '0 : wdata_q);
    cnt_d = (start_i || !cs_q) ? '0 : cnt_q + 3'd1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q <= 1'b0;
      wr_n_q <= 1'b1;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
    end else begin
      cs_q <= cs_d;
      wr_n_q <= wr_n_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ltc5548_pio_irq_master.sv
// ltc5548_pio_irq_master: hardware interrupt service for the LTC5548 edge-capture PIO,
// turning each irq into a read/clear sequence and one event record on a valid/ready stream.
module ltc5548_pio_irq_master
  import ltc5548_pio_pkg::*;
#(
  parameter int              WIDTH        = 2,
  parameter logic [WIDTH-1:0] MASK_INIT   = {WIDTH{1'b1}},
  parameter int              READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             pio_irq,
  input  logic             cfg_mask_wr,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic             init_done,
  output logic             busy
);
  localparam logic [WIDTH-1:0] ONES = '1;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cap_q, cap_d, lvl_q, lvl_d, pend_mask_q, pend_mask_d;
  logic              evt_valid_q, evt_valid_d, init_done_q, init_done_d, pend_q, pend_d;
  logic              start, wr, done, clr_pend;
  logic [2:0]        addr;
  logic [31:0]       wdata, rdata;
  logic              unused_rdata;
  assign unused_rdata = ^rdata;
  assign evt_valid = evt_valid_q;
  assign evt_edges = cap_q;
  assign evt_level = lvl_q;
  assign init_done = init_done_q;
  assign busy = state_q != S_IDLE;
  pio_bus_seq #(.READ_LATENCY(READ_LATENCY)) u_bus (
    .clk              (clk),
    .reset_n          (reset_n),
    .start_i          (start),
    .wr_i             (wr),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .avm_address_o    (avm_address),
    .avm_chipselect_o (avm_chipselect),
    .avm_write_n_o    (avm_write_n),
    .avm_writedata_o  (avm_writedata),
    .avm_readdata_i   (avm_readdata),
    .done_o           (done),
    .rdata_o          (rdata)
  );
  // Each state launches its successor's access on the done cycle so accesses chain back to back.
  always_comb begin
    state_d = state_q;
    start = 1'b0;
    wr = 1'b0;
    addr = ADDR_DATA;
    wdata = '0;
    clr_pend = 1'b0;
    cap_d = cap_q;
    lvl_d = lvl_q;
    evt_valid_d = evt_valid_q;
    init_done_d = init_done_q;
    case (state_q)
      S_INIT_MASK: begin
        start = !avm_chipselect || done;
        wr = 1'b1;
        addr = done ? ADDR_EDGE_CAP : ADDR_IRQ_MASK;
        wdata = done ? 32'(ONES) : 32'(MASK_INIT);
        state_d = done ? S_INIT_CLR : S_INIT_MASK;
      end
      S_INIT_CLR: begin
        state_d = done ? S_IDLE : S_INIT_CLR;
        init_done_d = init_done_q || done;
      end
      S_IDLE: begin
        start = pend_q || pio_irq;
        wr = pend_q;
        clr_pend = pend_q;
        addr = pend_q ? ADDR_IRQ_MASK : ADDR_EDGE_CAP;
        wdata = pend_q ? 32'(pend_mask_q) : '0;
        state_d = pend_q ? S_MASK_WR : (pio_irq ? S_RD_CAP : S_IDLE);
      end
      S_MASK_WR: state_d = done ? S_IDLE : S_MASK_WR;
      S_RD_CAP: begin
        cap_d = done ? rdata[WIDTH-1:0] : cap_q;
        start = done && rdata[WIDTH-1:0] != '0;
        addr = ADDR_DATA;
        state_d = !done ? S_RD_CAP : (rdata[WIDTH-1:0] == '0 ? S_IDLE : S_RD_DAT);
      end
      S_RD_DAT: begin
        lvl_d = done ? rdata[WIDTH-1:0] : lvl_q;
        start = done;
        wr = 1'b1;
        addr = ADDR_EDGE_CAP;
        wdata = 32'(cap_q);
        state_d = done ? S_CLR : S_RD_DAT;
      end
      S_CLR: begin
        evt_valid_d = done;
        state_d = done ? S_EMIT : S_CLR;
      end
      S_EMIT: begin
        evt_valid_d = !evt_ready;
        state_d = evt_ready ? S_IDLE : S_EMIT;
      end
      default: state_d = S_INIT_MASK;
    endcase
  end
  // A request arriving on the launch cycle of a mask write stays pending for the next pass.
  assign pend_d = cfg_mask_wr || (pend_q && !clr_pend);
  assign pend_mask_d = cfg_mask_wr ? cfg_mask : pend_mask_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT_MASK;
      cap_q <= '0;
      lvl_q <= '0;
      evt_valid_q <= 1'b0;
      init_done_q <= 1'b0;
      pend_q <= 1'b0;
      pend_mask_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q <= cap_d;
      lvl_q <= lvl_d;
      evt_valid_q <= evt_valid_d;
      init_done_q <= init_done_d;
      pend_q <= pend_d;
      pend_mask_q <= pend_mask_d;
    end
  end
endmodule

// File: tb/tb_ltc5548_pio_irq_master.sv
// tb_ltc5548_pio_irq_master: directed bench with a behavioural edge-capture PIO model.
module tb_ltc5548_pio_irq_master;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [31:0] avm_writedata, avm_readdata = '0;
  logic        pio_irq, cfg_mask_wr = 1'b0, evt_valid, evt_ready = 1'b0, init_done, busy;
  logic [1:0]  cfg_mask = '0, evt_edges, evt_level;
  logic [1:0]  in_port = '0, prev_in = '0, edge_cap = '0, irq_mask = '0;
  logic        force_en = 1'b0, force_val = 1'b0;
  int          checks = 0, errors = 0, cyc = 0;
  int          rd_cnt [8];
  typedef struct {int cyc; logic [2:0] a; logic [31:0] d;} wr_t;
  wr_t wlog[$];

  always #5 clk = ~clk;

  ltc5548_pio_irq_master #(.WIDTH(2), .MASK_INIT(2'b11), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .pio_irq(pio_irq),
    .cfg_mask_wr(cfg_mask_wr), .cfg_mask(cfg_mask), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_edges(evt_edges), .evt_level(evt_level), .init_done(init_done), .busy(busy)
  );

  // PIO model: rising-edge capture, write-1-to-clear edge register, 1-cycle read latency.
  assign pio_irq = force_en ? force_val : |(edge_cap & irq_mask);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_in <= in_port;
    if (avm_chipselect && !avm_write_n) begin
      wlog.push_back(wr_t'{cyc, avm_address, avm_writedata});
      if (avm_address == 3'd2) irq_mask <= avm_writedata[1:0];
    end
    edge_cap <= (edge_cap & ~((avm_chipselect && !avm_write_n && avm_address == 3'd3) ? avm_writedata[1:0] : 2'b00))
              | (in_port & ~prev_in);
    if (avm_chipselect && avm_write_n) begin
      rd_cnt[avm_address] <= rd_cnt[avm_address] + 1;
      avm_readdata <= {30'b0, avm_address == 3'd3 ? edge_cap : avm_address == 3'd2 ? irq_mask :
                              avm_address == 3'd0 ? in_port : 2'b00};
    end
  end

  task automatic test_reset;
    int base;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || avm_address !== 3'd0 || avm_writedata !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: got cs=%b wn=%b a=%0d wd=%h, want cs=0 wn=1 a=0 wd=0", avm_chipselect, avm_write_n, avm_address, avm_writedata);
    end
    checks++;
    if (evt_valid !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1 || evt_edges !== 2'b00 || evt_level !== 2'b00) begin
      errors++;
      $display("FAIL reset_status: got v=%b done=%b busy=%b e=%b l=%b, want 0 0 1 00 00", evt_valid, init_done, busy, evt_edges, evt_level);
    end
    base = wlog.size();
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (wlog.size() != base + 2) begin
      errors++;
      $display("FAIL init_count: got %0d writes, want 2", wlog.size() - base);
    end else begin
      checks++;
      if (wlog[base].a !== 3'd2 || wlog[base].d !== 32'h3) begin
        errors++;
        $display("FAIL init_mask: got a=%0d d=%h, want a=2 d=3", wlog[base].a, wlog[base].d);
      end
      checks++;
      if (wlog[base+1].a !== 3'd3 || wlog[base+1].d !== 32'h3 || wlog[base+1].cyc != wlog[base].cyc + 1) begin
        errors++;
        $display("FAIL init_clr: got a=%0d d=%h gap=%0d, want a=3 d=3 gap=1", wlog[base+1].a, wlog[base+1].d, wlog[base+1].cyc - wlog[base].cyc);
      end
    end
    checks++;
    if (init_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL init_done: got done=%b busy=%b, want 1 0", init_done, busy);
    end
  endtask

  task automatic test_single_edge;
    int t0 = -1, t1 = -1, base = wlog.size(), r3 = rd_cnt[3], r0 = rd_cnt[0];
    logic [1:0] e = '0, l = '0;
    evt_ready = 1'b1;
    in_port = 2'b10;
    for (int i = 0; i < 30 && t1 < 0; i++) begin
      @(negedge clk);
      if (t0 < 0 && !busy && pio_irq) t0 = cyc;
      if (evt_valid) begin t1 = cyc; e = evt_edges; l = evt_level; end
    end
    checks++;
    if (t0 < 0 || t1 < 0) begin
      errors++;
      $display("FAIL single_timeout: got t0=%0d t1=%0d, want both seen", t0, t1);
    end else if (t1 - t0 != 6) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, want 6", t1 - t0);
    end
    checks++;
    if (e !== 2'b10 || l !== 2'b10) begin
      errors++;
      $display("FAIL single_record: got edges=%b level=%b, want 10 10", e, l);
    end
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_onecycle: got valid=%b busy=%b, want 0 0", evt_valid, busy);
    end
    checks++;
    if (wlog.size() != base + 1 || rd_cnt[3] - r3 != 2 || rd_cnt[0] - r0 != 2) begin
      errors++;
      $display("FAIL single_bus: got writes=%0d rd3=%0d rd0=%0d, want 1 2 2", wlog.size() - base, rd_cnt[3] - r3, rd_cnt[0] - r0);
    end else begin
      checks++;
      if (wlog[base].a !== 3'd3 || wlog[base].d !== 32'h2) begin
        errors++;
        $display("FAIL single_clr: got a=%0d d=%h, want a=3 d=2", wlog[base].a, wlog[base].d);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit got = 0, stable = 1;
    logic [1:0] e = '0, l = '0;
    evt_ready = 1'b0;
    in_port = 2'b00;
    repeat (3) @(negedge clk);
    in_port = 2'b10;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = evt_valid; end
    checks++;
    if (!got) begin errors++; $display("FAIL bp_first: got no evt_valid, want one within 20 cycles"); end
    for (int i = 0; i < 20; i++) begin
      if (i == 3) in_port = 2'b11;
      @(negedge clk);
      if (evt_valid !== 1'b1 || evt_edges !== 2'b10 || evt_level !== 2'b10 || avm_chipselect !== 1'b0) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold: got v=%b e=%b l=%b cs=%b, want 1 10 10 0 held", evt_valid, evt_edges, evt_level, avm_chipselect);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b, want 0", evt_valid); end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (evt_valid) begin got = 1; e = evt_edges; l = evt_level; end
    end
    checks++;
    if (!got || e !== 2'b01 || l !== 2'b11) begin
      errors++;
      $display("FAIL bp_second: got seen=%0d edges=%b level=%b, want 1 01 11", got, e, l);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_irq_withdrawn;
    int base = wlog.size(), r3 = rd_cnt[3], r0 = rd_cnt[0];
    bit saw_busy, saw_valid = 0;
    force_en = 1'b1;
    force_val = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    saw_busy = busy;
    repeat (10) begin @(negedge clk); if (evt_valid) saw_valid = 1; end
    checks++;
    if (!saw_busy || saw_valid || busy !== 1'b0) begin
      errors++;
      $display("FAIL spur_flow: got busy_seen=%0d valid_seen=%0d busy=%b, want 1 0 0", saw_busy, saw_valid, busy);
    end
    checks++;
    if (wlog.size() != base || rd_cnt[3] - r3 != 2 || rd_cnt[0] - r0 != 0) begin
      errors++;
      $display("FAIL spur_bus: got writes=%0d rd3=%0d rd0=%0d, want 0 2 0", wlog.size() - base, rd_cnt[3] - r3, rd_cnt[0] - r0);
    end
  endtask

  task automatic test_mask_cfg;
    int base;
    bit got = 0, saw = 0;
    evt_ready = 1'b0;
    in_port = 2'b00;
    repeat (2) @(negedge clk);
    in_port = 2'b10;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = evt_valid; end
    base = wlog.size();
    cfg_mask_wr = 1'b1;
    cfg_mask = 2'b01;
    @(negedge clk);
    cfg_mask = 2'b00;
    @(negedge clk);
    cfg_mask_wr = 1'b0;
    repeat (3) @(negedge clk);
    evt_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (!got || wlog.size() != base + 1) begin
      errors++;
      $display("FAIL mask_count: got event=%0d writes=%0d, want 1 1", got, wlog.size() - base);
    end else begin
      checks++;
      if (wlog[base].a !== 3'd2 || wlog[base].d !== 32'h0) begin
        errors++;
        $display("FAIL mask_value: got a=%0d d=%h, want a=2 d=0", wlog[base].a, wlog[base].d);
      end
    end
    base = wlog.size();
    in_port = 2'b00;
    repeat (2) @(negedge clk);
    in_port = 2'b10;
    repeat (15) begin @(negedge clk); if (evt_valid || busy) saw = 1; end
    checks++;
    if (saw || pio_irq !== 1'b0 || wlog.size() != base) begin
      errors++;
      $display("FAIL mask_effect: got activity=%0d irq=%b writes=%0d, want 0 0 0", saw, pio_irq, wlog.size() - base);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    bit hit = 0;
    force_en = 1'b1;
    force_val = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (avm_chipselect && avm_write_n && avm_address == 3'd0) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_mid_reach: got no data read, want RD_DAT access"); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || avm_address !== 3'd0 || avm_writedata !== 32'd0 ||
        busy !== 1'b1 || init_done !== 1'b0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got cs=%b wn=%b a=%0d wd=%h busy=%b done=%b v=%b, want 0 1 0 0 1 0 0",
               avm_chipselect, avm_write_n, avm_address, avm_writedata, busy, init_done, evt_valid);
    end
    repeat (2) @(negedge clk);
    base = wlog.size();
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (wlog.size() != base + 2) begin
      errors++;
      $display("FAIL rst_mid_init: got %0d writes, want 2", wlog.size() - base);
    end else begin
      checks++;
      if (wlog[base].a !== 3'd2 || wlog[base].d !== 32'h3 || wlog[base+1].a !== 3'd3 || wlog[base+1].d !== 32'h3) begin
        errors++;
        $display("FAIL rst_mid_seq: got %0d/%h %0d/%h, want 2/3 3/3", wlog[base].a, wlog[base].d, wlog[base+1].a, wlog[base+1].d);
      end
    end
    checks++;
    if (init_done !== 1'b1 || busy !== 1'b0 || pio_irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_done: got done=%b busy=%b irq=%b, want 1 0 0", init_done, busy, pio_irq);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_back_to_back();
    test_irq_withdrawn();
    test_mask_cfg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
